pic_inta_master: RTL and testbench
==================================

# pic_inta_master

- CPU-side interrupt-acknowledge initiator for the PIC.
- Watches the PIC's `INT` output and runs the two-pulse `INTA` acknowledge sequence.
- Captures the 8-bit vector the PIC drives on the second pulse and hands it to the CPU core through a valid/ready handshake.
- Optionally issues the non-specific EOI write (OCW2) on the PIC bus when the core asks for it.

## Interface

Parameters:
- `PULSE_CYCLES`, default 2: width of each `INTA` pulse and of the `wr_n` strobe, in clocks (≥1).
- `GAP_CYCLES`, default 2: `INTA` low time between the first and second pulses (≥1).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; everything updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `INT`  in  1  interrupt request from the PIC, active-high.
- `D_in`  in  8  PIC data bus; carries the vector during the second `INTA`.
- `INTA`  out  1  acknowledge to the PIC, active-high.
- `cs_n`  out  1  PIC chip select, active-low.
- `wr_n`  out  1  PIC write strobe, active-low.
- `a0`  out  1  PIC address line.
- `d_out`  out  8  write data to the PIC.
- `d_oe`  out  1  `d_out` drive enable.
- `int_en`  in  1  core interrupt-enable flag.
- `vec_valid`  out  1  captured vector available.
- `vec_data`  out  8  captured vector.
- `vec_ready`  in  1  core accepts the vector.
- `eoi_req`  in  1  core requests a non-specific EOI; level, held until `eoi_ack`.
- `eoi_ack`  out  1  one-cycle pulse when the EOI write has finished.
- `busy`  out  1  high in every state except IDLE.

## Operation

Reset values:
- `INTA`=0, `cs_n`=1, `wr_n`=1, `a0`=0, `d_out`=8'h00, `d_oe`=0.
- `vec_valid`=0, `vec_data`=8'h00, `eoi_ack`=0, `busy`=0.
- State = IDLE; counter = 0.
- `rst` asserted in any state, including mid-pulse or mid-write, forces all reset values on the next edge. No partial pulse is completed.

States:
- IDLE: every output inactive.
  - If `eoi_req`=1 (EOI build only) → EOI_SETUP. EOI wins over a simultaneous `INT`, because it clears the PIC's ISR bit first.
  - Otherwise, if `INT`=1, `int_en`=1 and `vec_valid`=0 → ACK1.
- ACK1: `INTA`=1 for `PULSE_CYCLES` → GAP. Loss of `INT` or `int_en` after entry does not abort; the sequence always finishes.
- GAP: `INTA`=0 for `GAP_CYCLES` → ACK2.
- ACK2: `INTA`=1 for `PULSE_CYCLES`.
  - `D_in` is registered into `vec_data` on the final ACK2 edge.
  - → VEC.
- VEC: `vec_valid`=1; `vec_data` stays stable.
  - The state is left on the edge where `vec_valid`&`vec_ready`=1; `vec_valid`=0 on the next cycle → IDLE.
  - No new acknowledge starts while `vec_valid`=1.
- EOI_SETUP (1 cycle): `cs_n`=0, `a0`=0, `d_oe`=1, `d_out`=8'h20 (OCW2 non-specific EOI), `wr_n`=1.
- EOI_STROBE: as EOI_SETUP but `wr_n`=0, for `PULSE_CYCLES`.
- EOI_HOLD (1 cycle): `wr_n`=1; `cs_n`, `a0`, `d_out`, `d_oe` held; `eoi_ack`=1 → IDLE.
  - On the IDLE cycle that follows: `cs_n`=1, `d_oe`=0, `d_out`=8'h00.

Counter and registers:
- One down-counter, width `$clog2(max(PULSE_CYCLES,GAP_CYCLES)+1)`.
- It loads N−1 on state entry; the state exits on the count-0 cycle.
- All outputs are registered; no combinational paths from inputs to outputs.

## Timing

- IDLE decision at cycle t:
  - `INTA` high during t+1 … t+P.
  - Low during t+P+1 … t+P+G.
  - High during t+P+G+1 … t+2P+G.
  - `vec_valid` first high at t+2P+G+1 (defaults: t+7).
- `vec_ready` already high when `vec_valid` rises: handshake completes that cycle; IDLE at t+2P+G+2.
- At least one IDLE cycle separates back-to-back acknowledge sequences, so `INT` is re-sampled after the PIC drops it.
- EOI from IDLE decision at t:
  - SETUP at t+1.
  - `wr_n` low during t+2 … t+P+1.
  - HOLD and `eoi_ack` at t+P+2.
  - Bus released at t+P+3.
- Setup and hold of write data are each ≥1 clock around the `wr_n` strobe.

## Configuration

- `PIC_INTA_EOI_WRITE_EN` defined: EOI_SETUP, EOI_STROBE and EOI_HOLD exist, and `eoi_req` is serviced as described above.
- Undefined:
  - The EOI states are not compiled.
  - `eoi_req` is ignored and `eoi_ack` stays 0.
  - `cs_n`=1, `wr_n`=1, `a0`=0, `d_out`=8'h00 and `d_oe`=0 permanently. The PIC must then run in AEOI mode.

## Test plan

- Defaults; `INT`=1, `int_en`=1, `vec_ready`=1, `D_in`=8'hAA only during the second pulse → `INTA` pattern 0,1,1,0,0,1,1,0; `vec_data`=8'hAA, `vec_valid` for exactly 1 cycle at t+7.
- `vec_ready`=0 for 5 cycles after `vec_valid` rises → `vec_valid`/`vec_data` stable for 5 cycles; no `INTA` while `INT` is held high; a new sequence starts only after the handshake plus 1 IDLE cycle.
- `int_en`=0 with `INT`=1 for 10 cycles → `INTA` stays 0 and `busy`=0; raise `int_en` → sequence starts on the next cycle.
- EOI build, `eoi_req` and `INT` rise together → write 8'h20 with `a0`=0 and `wr_n` low for 2 cycles; `eoi_ack` at t+4; acknowledge sequence starts after the return to IDLE.
- `rst` pulsed during the first cycle of ACK2 → next cycle `INTA`=0, `busy`=0, `vec_valid`=0; no vector delivered.
- `PULSE_CYCLES`=1, `GAP_CYCLES`=3 → `INTA` 1,0,0,0,1; `vec_valid` at t+6.

Source files
------------

// File: rtl/pic_inta_master_if.sv
// PIC bus plus core-side vector/EOI handshake for pic_inta_master.
interface pic_inta_master_if;
  logic       INT;
  logic [7:0] D_in;
  logic       INTA;
  logic       cs_n;
  logic       wr_n;
  logic       a0;
  logic [7:0] d_out;
  logic       d_oe;
  logic       int_en;
  logic       vec_valid;
  logic [7:0] vec_data;
  logic       vec_ready;
  logic       eoi_req;
  logic       eoi_ack;
  logic       busy;

  modport master (
    input  INT, D_in, int_en, vec_ready, eoi_req,
    output INTA, cs_n, wr_n, a0, d_out, d_oe, vec_valid, vec_data, eoi_ack, busy
  );

  modport slave (
    output INT, D_in, int_en, vec_ready, eoi_req,
    input  INTA, cs_n, wr_n, a0, d_out, d_oe, vec_valid, vec_data, eoi_ack, busy
  );
endinterface

// File: rtl/pic_inta_master.sv
// CPU-side two-pulse INTA acknowledge initiator with vector handoff.
// Define PIC_INTA_EOI_WRITE_EN to add the non-specific EOI (OCW2) bus write.
module pic_inta_master #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input logic             clk,
  input logic             rst,
  pic_inta_master_if.master bus
);

  localparam int unsigned MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
  localparam logic [7:0]    OCW2_EOI = 8'h20;

  typedef enum logic [2:0] {
    IDLE,
    ACK1,
    GAP,
    ACK2,
    VEC
`ifdef PIC_INTA_EOI_WRITE_EN
    ,
    EOI_SETUP,
    EOI_STROBE,
    EOI_HOLD
`endif
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          cnt_zero;

  assign cnt_zero = (cnt == '0);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
`ifdef PIC_INTA_EOI_WRITE_EN
        // EOI first so the PIC's ISR bit is cleared before the next acknowledge.
        if (bus.eoi_req) begin
          state_n = EOI_SETUP;
          cnt_n   = '0;
        end else
`endif
        if (bus.INT && bus.int_en && !bus.vec_valid) begin
          state_n = ACK1;
          cnt_n   = PULSE_LD;
        end
      end
      ACK1: begin
        if (cnt_zero) begin
          state_n = GAP;
          cnt_n   = GAP_LD;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt_zero) begin
          state_n = ACK2;
          cnt_n   = PULSE_LD;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      ACK2: begin
        if (cnt_zero) begin
          state_n = VEC;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      VEC: begin
        if (bus.vec_ready) state_n = IDLE;
      end
`ifdef PIC_INTA_EOI_WRITE_EN
      EOI_SETUP: begin
        state_n = EOI_STROBE;
        cnt_n   = PULSE_LD;
      end
      EOI_STROBE: begin
        if (cnt_zero) begin
          state_n = EOI_HOLD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      EOI_HOLD: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
`endif
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

`ifdef PIC_INTA_EOI_WRITE_EN
  logic eoi_bus_n;
  assign eoi_bus_n = (state_n == EOI_SETUP) || (state_n == EOI_STROBE) || (state_n == EOI_HOLD);
`else
  logic unused_eoi_req;
  assign unused_eoi_req = bus.eoi_req;
`endif

  // Outputs are registered from the next state so each one lines up with its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      bus.INTA      <= 1'b0;
      bus.cs_n      <= 1'b1;
      bus.wr_n      <= 1'b1;
      bus.a0        <= 1'b0;
      bus.d_out     <= '0;
      bus.d_oe      <= 1'b0;
      bus.vec_valid <= 1'b0;
      bus.vec_data  <= '0;
      bus.eoi_ack   <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      bus.INTA      <= (state_n == ACK1) || (state_n == ACK2);
      bus.vec_valid <= (state_n == VEC);
      bus.busy      <= (state_n != IDLE);
      bus.a0        <= 1'b0;
      if (state == ACK2 && cnt_zero) bus.vec_data <= bus.D_in;
`ifdef PIC_INTA_EOI_WRITE_EN
      bus.cs_n    <= !eoi_bus_n;
      bus.d_oe    <= eoi_bus_n;
      bus.d_out   <= eoi_bus_n ? OCW2_EOI : '0;
      bus.wr_n    <= (state_n != EOI_STROBE);
      bus.eoi_ack <= (state_n == EOI_HOLD);
`else
      bus.cs_n    <= 1'b1;
      bus.d_oe    <= 1'b0;
      bus.d_out   <= '0;
      bus.wr_n    <= 1'b1;
      bus.eoi_ack <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_pic_inta_master.sv
// Bench for pic_inta_master: directed tables/sequences plus random traffic
// checked against a timeline model, on a default and a P=1/G=3 instance.
module tb_pic_inta_master;

  localparam int P0 = 2, G0 = 2, P1 = 1, G1 = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pic_inta_master_if ifc0 ();
  pic_inta_master_if ifc1 ();

  pic_inta_master #(.PULSE_CYCLES(P0), .GAP_CYCLES(G0)) dut0 (.clk(clk), .rst(rst), .bus(ifc0));
  pic_inta_master #(.PULSE_CYCLES(P1), .GAP_CYCLES(G1)) dut1 (.clk(clk), .rst(rst), .bus(ifc1));

  int errors = 0;
  int checks = 0;
  int cnum   = 0;

  logic       rst_s, int_s, en_s, rdy_s, eoi_s;
  logic [7:0] din_s;

  // Model: cycle of the acknowledge / EOI decision (-1 = none) and last vector.
  int         t0[2];
  int         e0[2];
  logic [7:0] vd[2];

  typedef struct {
    logic INT, en, rdy;
    logic [7:0] d;
    logic inta, vv, busy;
    logic [7:0] vd;
    logic inta1, vv1;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h want %0h", name, cnum, act, exp);
    end
  endtask

  task automatic model_step(input int i);
    int p, g, k;
    logic inta, cs_n, wr_n, a0, d_oe, vv, eoi_ack, busy;
    logic [7:0] d_out, vdata;
    logic e_inta, e_vv, e_busy, e_cs, e_wr, e_doe, e_ack;
    logic [7:0] e_dout;
    p = (i == 0) ? P0 : P1;
    g = (i == 0) ? G0 : G1;
    if (i == 0) begin
      inta = ifc0.INTA; cs_n = ifc0.cs_n; wr_n = ifc0.wr_n; a0 = ifc0.a0; d_out = ifc0.d_out;
      d_oe = ifc0.d_oe; vv = ifc0.vec_valid; vdata = ifc0.vec_data; eoi_ack = ifc0.eoi_ack; busy = ifc0.busy;
    end else begin
      inta = ifc1.INTA; cs_n = ifc1.cs_n; wr_n = ifc1.wr_n; a0 = ifc1.a0; d_out = ifc1.d_out;
      d_oe = ifc1.d_oe; vv = ifc1.vec_valid; vdata = ifc1.vec_data; eoi_ack = ifc1.eoi_ack; busy = ifc1.busy;
    end
    e_inta = 0; e_vv = 0; e_busy = 0; e_cs = 1; e_wr = 1; e_doe = 0; e_ack = 0; e_dout = 8'h00;
    k = 0;
    if (t0[i] >= 0) begin
      k = cnum - t0[i];
      e_busy = 1;
      e_inta = (k >= 1 && k <= p) || (k >= p + g + 1 && k <= 2 * p + g);
      e_vv   = (k >= 2 * p + g + 1);
    end else if (e0[i] >= 0) begin
      k = cnum - e0[i];
      e_busy = 1; e_cs = 0; e_doe = 1; e_dout = 8'h20;
      e_wr  = !(k >= 2 && k <= p + 1);
      e_ack = (k == p + 2);
    end
    chk($sformatf("m%0d inta", i), inta, e_inta);
    chk($sformatf("m%0d vec_valid", i), vv, e_vv);
    chk($sformatf("m%0d vec_data", i), vdata, vd[i]);
    chk($sformatf("m%0d busy", i), busy, e_busy);
    chk($sformatf("m%0d cs_n", i), cs_n, e_cs);
    chk($sformatf("m%0d wr_n", i), wr_n, e_wr);
    chk($sformatf("m%0d a0", i), a0, 1'b0);
    chk($sformatf("m%0d d_out", i), d_out, e_dout);
    chk($sformatf("m%0d d_oe", i), d_oe, e_doe);
    chk($sformatf("m%0d eoi_ack", i), eoi_ack, e_ack);
    if (rst_s) begin
      t0[i] = -1; e0[i] = -1; vd[i] = 8'h00;
    end else if (t0[i] >= 0) begin
      if (k == 2 * p + g) vd[i] = din_s;
      if (e_vv && rdy_s) t0[i] = -1;
    end else if (e0[i] >= 0) begin
      if (k == p + 2) e0[i] = -1;
    end else begin
`ifdef PIC_INTA_EOI_WRITE_EN
      if (eoi_s) e0[i] = cnum;
      else
`endif
      if (int_s && en_s) t0[i] = cnum;
    end
  endtask

  task automatic drive();
    rst = rst_s;
    ifc0.INT = int_s; ifc0.int_en = en_s; ifc0.vec_ready = rdy_s; ifc0.eoi_req = eoi_s; ifc0.D_in = din_s;
    ifc1.INT = int_s; ifc1.int_en = en_s; ifc1.vec_ready = rdy_s; ifc1.eoi_req = eoi_s; ifc1.D_in = din_s;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1 drive();
    @(negedge clk);
    cnum++;
    model_step(0);
    model_step(1);
  endtask

  task automatic drain(input int n);
    int_s = 0; eoi_s = 0; rdy_s = 1; en_s = 1; rst_s = 0;
    repeat (n) cyc();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin t0[i] = -1; e0[i] = -1; vd[i] = 8'h00; end
    rst_s = 1; int_s = 0; en_s = 1; rdy_s = 1; eoi_s = 0; din_s = 8'h00;
    drive();
    repeat (2) cyc();
    chk("reset inta", ifc0.INTA, 1'b0);
    chk("reset cs_n", ifc0.cs_n, 1'b1);
    chk("reset vec_data", ifc0.vec_data, 8'h00);
    rst_s = 0;
    repeat (3) cyc();

    // Basic acknowledge, both pulse shapes side by side.
    tbl[0] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'hAA, 1'b0, 1'b0};
    for (int r = 0; r < 10; r++) begin
      int_s = tbl[r].INT; en_s = tbl[r].en; rdy_s = tbl[r].rdy; din_s = tbl[r].d;
      cyc();
      chk($sformatf("tbl%0d inta", r), ifc0.INTA, tbl[r].inta);
      chk($sformatf("tbl%0d vec_valid", r), ifc0.vec_valid, tbl[r].vv);
      chk($sformatf("tbl%0d busy", r), ifc0.busy, tbl[r].busy);
      chk($sformatf("tbl%0d vec_data", r), ifc0.vec_data, tbl[r].vd);
      chk($sformatf("tbl%0d inta p1g3", r), ifc1.INTA, tbl[r].inta1);
      chk($sformatf("tbl%0d vec_valid p1g3", r), ifc1.vec_valid, tbl[r].vv1);
    end
    drain(6);

    // Core stalls the vector for 5 cycles with INT held high.
    int_s = 1; en_s = 1; rdy_s = 0; din_s = 8'h5C;
    cyc();
    repeat (6) cyc();
    for (int s = 0; s < 5; s++) begin
      cyc();
      chk("stall vec_valid", ifc0.vec_valid, 1'b1);
      chk("stall vec_data", ifc0.vec_data, 8'h5C);
      chk("stall inta", ifc0.INTA, 1'b0);
    end
    rdy_s = 1;
    cyc();
    chk("handshake vec_valid", ifc0.vec_valid, 1'b1);
    cyc();
    chk("post-hs idle vec_valid", ifc0.vec_valid, 1'b0);
    chk("post-hs idle busy", ifc0.busy, 1'b0);
    cyc();
    chk("restart inta", ifc0.INTA, 1'b1);
    drain(14);

    // Interrupts masked by int_en.
    int_s = 1; en_s = 0;
    for (int s = 0; s < 10; s++) begin
      cyc();
      chk("masked inta", ifc0.INTA, 1'b0);
      chk("masked busy", ifc0.busy, 1'b0);
    end
    en_s = 1;
    cyc();
    cyc();
    chk("unmask inta", ifc0.INTA, 1'b1);
    chk("unmask busy", ifc0.busy, 1'b1);
    drain(14);

    // Reset during the first ACK2 cycle: no vector delivered.
    int_s = 1; din_s = 8'h77;
    cyc();
    int_s = 0;
    repeat (4) cyc();
    rst_s = 1;
    cyc();
    chk("ack2 entry inta", ifc0.INTA, 1'b1);
    rst_s = 0;
    cyc();
    chk("after rst inta", ifc0.INTA, 1'b0);
    chk("after rst busy", ifc0.busy, 1'b0);
    chk("after rst vec_valid", ifc0.vec_valid, 1'b0);
    for (int s = 0; s < 8; s++) begin
      cyc();
      chk("no vector vec_valid", ifc0.vec_valid, 1'b0);
      chk("no vector vec_data", ifc0.vec_data, 8'h00);
    end

    // EOI request together with INT.
    int_s = 1; eoi_s = 1; din_s = 8'h31;
`ifdef PIC_INTA_EOI_WRITE_EN
    cyc();
    chk("eoi decide cs_n", ifc0.cs_n, 1'b1);
    cyc();
    chk("eoi setup cs_n", ifc0.cs_n, 1'b0);
    chk("eoi setup wr_n", ifc0.wr_n, 1'b1);
    chk("eoi setup d_out", ifc0.d_out, 8'h20);
    chk("eoi setup d_oe", ifc0.d_oe, 1'b1);
    for (int s = 0; s < 2; s++) begin
      cyc();
      chk("eoi strobe wr_n", ifc0.wr_n, 1'b0);
      chk("eoi strobe a0", ifc0.a0, 1'b0);
      chk("eoi strobe inta", ifc0.INTA, 1'b0);
    end
    cyc();
    chk("eoi hold ack", ifc0.eoi_ack, 1'b1);
    chk("eoi hold wr_n", ifc0.wr_n, 1'b1);
    chk("eoi hold cs_n", ifc0.cs_n, 1'b0);
    eoi_s = 0;
    cyc();
    chk("eoi release cs_n", ifc0.cs_n, 1'b1);
    chk("eoi release d_oe", ifc0.d_oe, 1'b0);
    chk("eoi release ack", ifc0.eoi_ack, 1'b0);
    cyc();
    chk("ack after eoi inta", ifc0.INTA, 1'b1);
`else
    cyc();
    for (int s = 0; s < 4; s++) begin
      cyc();
      chk("no-eoi cs_n", ifc0.cs_n, 1'b1);
      chk("no-eoi wr_n", ifc0.wr_n, 1'b1);
      chk("no-eoi eoi_ack", ifc0.eoi_ack, 1'b0);
      chk("no-eoi inta", ifc0.INTA, (s < 2) ? 1'b1 : 1'b0);
    end
`endif
    drain(14);

    // Random traffic against the timeline model.
    for (int n = 0; n < 3000; n++) begin
      rst_s = ($urandom_range(0, 99) == 0);
      int_s = ($urandom_range(0, 3) != 0);
      en_s  = ($urandom_range(0, 7) != 0);
      rdy_s = ($urandom_range(0, 2) != 0);
      eoi_s = ($urandom_range(0, 7) == 0);
      din_s = 8'($urandom);
      cyc();
    end
    drain(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
